axis_i2c_cfg_seq: RTL and testbench
===================================

# axis_i2c_cfg_seq

Upstream command source for `axis_i2c_top`. It walks a compile-time table of I2C register writes, given as {device address, register, data}. Each entry goes out as a 3-byte AXI-Stream frame to the I2C master, and the sequencer waits for the master's completion/NACK status before moving on. It brings external peripherals to a known configuration after reset, with no processor involved.

## Interface
Parameters:
- `N_ENTRIES`, 4: number of table entries (1..256).
- `GAP_CYCLES`, 16: idle cycles between frames after an ACKed entry (0 allowed).
- `TIMEOUT_CYCLES`, 65535: maximum wait for `i2c_done` before the entry counts as failed.
- `MAX_RETRY`, 3: re-sends per entry after a failure (used only when retry is compiled in).

Ports:
- `clk` in 1: system clock.
- `arstn` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse that starts the sequence.
- `m_axis_tdata` out 8: frame byte.
- `m_axis_tvalid` out 1: AXIS valid.
- `m_axis_tready` in 1: AXIS ready from the I2C master.
- `m_axis_tlast` out 1: asserted on byte 2 of each frame.
- `i2c_done` in 1: single-cycle pulse from the master when a transaction finishes.
- `i2c_nack` in 1: qualified by `i2c_done`; 1 means the slave NACKed.
- `busy` out 1: sequence in progress.
- `done` out 1: all entries ACKed; sticky until the next `start` or reset.
- `error` out 1: sequence aborted; sticky until the next `start` or reset.
- `err_idx` out 8: index of the failing entry; valid while `error` = 1.

## Operation
- Table entry format is 24 bits: bit 23 is unused, then `dev[6:0]`, `reg[7:0]`, `data[7:0]`.
- Frame bytes:
  - byte0 = {dev, 1'b0} (write).
  - byte1 = reg.
  - byte2 = data, with `tlast` = 1.
- FSM states and transitions:
  - IDLE: on `start`, go to LOAD with idx = 0 and retry count = 0.
  - LOAD: one ROM read cycle, then SEND.
  - SEND: three beats. After the byte2 handshake, go to WAIT.
  - WAIT: on `i2c_done` with `i2c_nack` = 0, go to GAP. On `i2c_done` with `i2c_nack` = 1, or when the timeout counter expires, the entry has failed (see Configuration).
  - GAP: count `GAP_CYCLES`, then idx++ and go to LOAD. If idx was `N_ENTRIES`-1, go to DONE instead. With `GAP_CYCLES` = 0, GAP lasts zero cycles and the transition happens directly from WAIT.
  - DONE and ERROR: terminal. A `start` pulse restarts from idx 0 and clears `done`, `error` and `err_idx`.
- `start` is ignored in LOAD, SEND, WAIT and GAP.
- `i2c_done` is ignored outside WAIT.
- `busy` = 1 in LOAD, SEND, WAIT and GAP.
- Timeout counter:
  - Width is $clog2(`TIMEOUT_CYCLES`+1).
  - Cleared on entry to WAIT.
  - Expires when the count reaches `TIMEOUT_CYCLES`.
  - If `i2c_done` arrives in the same cycle as expiry, `i2c_done` wins.

## Timing
- Reset values: every output is 0, FSM is in IDLE, idx and counters are 0. Reset takes effect asynchronously, including mid-frame: `m_axis_tvalid` drops immediately and no partial frame is resumed after reset.
- `start` sampled high in cycle T:
  - `busy` = 1 in T+1 (LOAD).
  - byte0 is presented with `tvalid` = 1 in T+2.
- AXIS rules:
  - `tdata` and `tlast` are held stable while `tvalid` = 1 and `tready` = 0.
  - A beat transfers on a rising edge with `tvalid` && `tready`.
  - The next beat is presented in the following cycle, so there are no bubbles inside a frame when `tready` is held high.
  - `tvalid` never depends combinationally on `tready`.
  - `tvalid` = 0 outside SEND.
- `done`/`error` assert in the cycle after the deciding `i2c_done` (or after the GAP end, or the timeout), and `busy` deasserts in that same cycle.

## Configuration
- `AXIS_I2C_CFG_RETRY_EN` defined:
  - A failed entry returns to LOAD with the same idx and retry count + 1, with no gap.
  - Once the retry count equals `MAX_RETRY` and the entry fails again, go to ERROR with `err_idx` = idx.
  - The retry count clears when an entry is ACKed.
- Undefined: the first failure goes straight to ERROR, and the retry counter logic is absent.

## Structure
- Package `axis_i2c_pkg` holds:
  - the state enum `cfg_state_e`;
  - the packed struct `cfg_entry_t` {pad, dev, reg, data};
  - the default table constant `CFG_TABLE` (array of `cfg_entry_t` sized by `N_ENTRIES`).
- Sub-module `axis_i2c_cfg_rom`: registered synchronous read of `CFG_TABLE`, idx in, entry out, 1-cycle latency (this latency is what the LOAD state covers).

## Test plan
- Table of 2 entries {0x50,0x10,0xAA}, {0x50,0x11,0x55}, `tready` held at 1, model ACKs each frame 20 cycles after `tlast` → stream reads 0xA0,0x10,0xAA (tlast), then 0xA0,0x11,0x55 (tlast); `done` = 1, `error` = 0.
- Random `tready` stalls at 50% → byte order and `tlast` position unchanged; `tdata` stable throughout every stall.
- Retry, with macro defined and `MAX_RETRY` = 3:
  - NACK on entry 1 twice → entry 1 sent 3 times, then `done`.
  - NACK 4 times → `error` = 1, `err_idx` = 1.
- Retry, with macro undefined: a single NACK on entry 0 → `error` = 1 and `err_idx` = 0 in the cycle after `i2c_done`.
- No `i2c_done` with `TIMEOUT_CYCLES` = 100 → failure declared 100 cycles after entry to WAIT.
- Edge cases:
  - Assert `arstn` low during byte1 → all outputs 0 immediately.
  - A later `start` → transmission restarts at entry 0 byte0.
  - `start` pulsed while `busy` → ignored.

Source files
------------

// File: rtl/axis_i2c_pkg.sv
// Shared types and the default register-write table for the I2C config
// sequencer. The retry feature is selected with the macro
// AXIS_I2C_CFG_RETRY_EN in the sequencer top; nothing here depends on it.
package axis_i2c_pkg;

  // Sequencer states; the top maps these onto plain 3-bit constants.
  typedef enum logic [2:0] {
    CFG_IDLE  = 3'd0,
    CFG_LOAD  = 3'd1,
    CFG_SEND  = 3'd2,
    CFG_WAIT  = 3'd3,
    CFG_GAP   = 3'd4,
    CFG_DONE  = 3'd5,
    CFG_ERROR = 3'd6
  } cfg_state_e;

  // One table entry: {pad, 7-bit device address, register, data}.
  typedef struct packed {
    logic       pad;
    logic [6:0] dev;
    logic [7:0] regaddr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam int CFG_N_DEF = 4;

  function automatic cfg_entry_t cfg_entry(input logic [6:0] dev_i,
                                           input logic [7:0] reg_i,
                                           input logic [7:0] data_i);
    cfg_entry = '{pad: 1'b0, dev: dev_i, regaddr: reg_i, data: data_i};
  endfunction

  // Default table, entry 0 in the least significant slot.
  localparam cfg_entry_t [CFG_N_DEF-1:0] CFG_TABLE = {
    cfg_entry(7'h1A, 8'h01, 8'h3C),
    cfg_entry(7'h1A, 8'h00, 8'h80),
    cfg_entry(7'h50, 8'h11, 8'h55),
    cfg_entry(7'h50, 8'h10, 8'hAA)
  };

endpackage

// File: rtl/axis_i2c_cfg_rom.sv
// Registered table lookup: the entry selected by idx_i appears one cycle
// later. Out-of-range indices read as zero.
module axis_i2c_cfg_rom
  import axis_i2c_pkg::*;
#(
  parameter int                         N_ENTRIES = CFG_N_DEF,
  parameter cfg_entry_t [N_ENTRIES-1:0] TABLE     = CFG_TABLE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] idx_i,
  output cfg_entry_t entry_o
);

  cfg_entry_t entry_d;
  cfg_entry_t entry_q;

  // Select the table entry matching the requested index.
  always_comb begin
    entry_d = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (idx_i == 8'(i)) entry_d = TABLE[i];
    end
  end

  // Register the lookup so the read has a fixed one-cycle latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) entry_q <= '0;
    else         entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/axis_i2c_cfg_seq.sv
// Walks a table of I2C register writes after start, sending each entry as a
// 3-byte AXI-Stream frame {dev,W}, reg, data(tlast) and waiting for the I2C
// master's done/nack status. Optional retry: define AXIS_I2C_CFG_RETRY_EN.
//
// Handshake: a beat moves on a rising edge where tvalid && tready; tvalid is
// a pure function of state (never of tready), and tdata/tlast hold while the
// beat is pending.
module axis_i2c_cfg_seq
  import axis_i2c_pkg::*;
#(
  parameter int                         N_ENTRIES      = CFG_N_DEF,
  parameter int                         GAP_CYCLES     = 16,
  parameter int                         TIMEOUT_CYCLES = 65535,
  parameter int                         MAX_RETRY      = 3,
  parameter cfg_entry_t [N_ENTRIES-1:0] TABLE          = CFG_TABLE
) (
  input  logic       clk,
  input  logic       arstn,
  input  logic       start,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] err_idx
);

  localparam logic [2:0] S_IDLE  = CFG_IDLE;
  localparam logic [2:0] S_LOAD  = CFG_LOAD;
  localparam logic [2:0] S_SEND  = CFG_SEND;
  localparam logic [2:0] S_WAIT  = CFG_WAIT;
  localparam logic [2:0] S_GAP   = CFG_GAP;
  localparam logic [2:0] S_DONE  = CFG_DONE;
  localparam logic [2:0] S_ERROR = CFG_ERROR;

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0]    IDX_LAST = 8'(N_ENTRIES - 1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [7:0]    err_idx_q, err_idx_d;
  logic          restart, ack, fail, advance, retry_spent;
  cfg_entry_t    rom_entry;
  logic          unused_pad;

  axis_i2c_cfg_rom #(
    .N_ENTRIES (N_ENTRIES),
    .TABLE     (TABLE)
  ) u_rom (
    .clk_i   (clk),
    .rst_ni  (arstn),
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  assign unused_pad = rom_entry.pad;
  assign restart    = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

`ifdef AXIS_I2C_CFG_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_d;

  // Retry count: cleared on restart or ACK, bumped on each non-final failure.
  always_comb begin
    retry_d = retry_q;
    if (restart || ack)          retry_d = '0;
    else if (fail && !retry_spent) retry_d = retry_q + 1'b1;
  end

  // Retry count register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) retry_q <= '0;
    else        retry_q <= retry_d;
  end

  assign retry_spent = (retry_q == RETRY_MAX);
`else
  assign retry_spent = 1'b1;
`endif

  // Next-state logic: frame sequencing, status wait, inter-frame gap.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    ack       = 1'b0;
    fail      = 1'b0;
    advance   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_LOAD;
          idx_d     = 8'd0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_idx_d = 8'd0;
        end
      end
      S_LOAD: begin
        state_d = S_SEND;
        beat_d  = 2'd0;
      end
      S_SEND: begin
        if (m_axis_tready) begin
          if (beat_q == 2'd2) begin
            state_d = S_WAIT;
            beat_d  = 2'd0;
            tmo_d   = '0;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      S_WAIT: begin
        // A done pulse takes priority over a timeout in the same cycle.
        if (i2c_done) begin
          ack  = !i2c_nack;
          fail = i2c_nack;
        end else if (tmo_q == TMO_MAX) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) advance = 1'b1;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (ack) begin
      if (GAP_CYCLES == 0) begin
        advance = 1'b1;
      end else begin
        state_d = S_GAP;
        gap_d   = '0;
      end
    end

    if (advance) begin
      if (idx_q == IDX_LAST) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = S_LOAD;
        idx_d   = idx_q + 8'd1;
      end
    end

    if (fail) begin
      if (retry_spent) begin
        state_d   = S_ERROR;
        error_d   = 1'b1;
        err_idx_d = idx_q;
      end else begin
        state_d = S_LOAD;
      end
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q   <= S_IDLE;
      beat_q    <= 2'd0;
      idx_q     <= 8'd0;
      tmo_q     <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Frame byte mux; zero whenever no beat is offered.
  always_comb begin
    m_axis_tdata = 8'h00;
    if (state_q == S_SEND) begin
      case (beat_q)
        2'd0:    m_axis_tdata = {rom_entry.dev, 1'b0};
        2'd1:    m_axis_tdata = rom_entry.regaddr;
        default: m_axis_tdata = rom_entry.data;
      endcase
    end
  end

  assign m_axis_tvalid = (state_q == S_SEND);
  assign m_axis_tlast  = (state_q == S_SEND) && (beat_q == 2'd2);
  assign busy          = (state_q == S_LOAD) || (state_q == S_SEND) ||
                         (state_q == S_WAIT) || (state_q == S_GAP);
  assign done          = done_q;
  assign error         = error_q;
  assign err_idx       = err_idx_q;

endmodule

// File: tb/tb_axis_i2c_cfg_seq.sv
// Directed bench for axis_i2c_cfg_seq with a 2-entry table
// {0x50,0x10,0xAA}, {0x50,0x11,0x55}. Build with AXIS_I2C_CFG_RETRY_EN
// defined to exercise the retry scenarios instead of the abort ones.
module tb_axis_i2c_cfg_seq;
  import axis_i2c_pkg::*;

  localparam cfg_entry_t [1:0] TB_TABLE = {
    cfg_entry(7'h50, 8'h11, 8'h55),
    cfg_entry(7'h50, 8'h10, 8'hAA)
  };

  logic       clk = 1'b0;
  logic       arstn, start, m_axis_tready, i2c_done, i2c_nack;
  logic [7:0] m_axis_tdata, err_idx;
  logic       m_axis_tvalid, m_axis_tlast, busy, done, error;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] cap_q[$];
  int         tlast_seen = 0;
  int         resp_frames = 0;
  int         plan_base = 0;
  int         resp_delay = 20;
  bit         resp_en = 1'b0;
  logic [7:0] nack_mask = 8'h00;

  axis_i2c_cfg_seq #(
    .N_ENTRIES      (2),
    .GAP_CYCLES     (4),
    .TIMEOUT_CYCLES (100),
    .MAX_RETRY      (3),
    .TABLE          (TB_TABLE)
  ) dut (
    .clk           (clk),
    .arstn         (arstn),
    .start         (start),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .i2c_done      (i2c_done),
    .i2c_nack      (i2c_nack),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_idx       (err_idx)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

  // Beat monitor: a beat offered with tready at the negedge moves on the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (arstn && m_axis_tvalid && m_axis_tready) begin
        cap_q.push_back({m_axis_tlast, m_axis_tdata});
        if (m_axis_tlast) tlast_seen++;
      end
    end
  end

  // I2C master model: one done pulse resp_delay cycles after each tlast;
  // nack_mask bit k NACKs frame k counted from plan_base.
  initial begin
    int timer;
    int handled;
    int fidx;
    timer = -1;
    handled = 0;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (timer == 0) begin
        fidx = resp_frames - plan_base;
        i2c_done = 1'b1;
        i2c_nack = (fidx >= 0 && fidx < 8) ? nack_mask[fidx] : 1'b0;
        resp_frames++;
        timer = -1;
      end else if (timer > 0) begin
        timer--;
      end
      if (handled != tlast_seen) begin
        handled = tlast_seen;
        if (resp_en) timer = resp_delay - 1;
      end
    end
  end

  // Driver tasks
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  function automatic void push_e0();
    exp_q.push_back(9'h0A0); exp_q.push_back(9'h010); exp_q.push_back(9'h1AA);
  endfunction

  function automatic void push_e1();
    exp_q.push_back(9'h0A0); exp_q.push_back(9'h011); exp_q.push_back(9'h155);
  endfunction

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    arstn = 1'b0; start = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h want 00", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error); end
    checks++; if (err_idx !== 8'h00) begin errors++; $display("FAIL rst_err_idx: got %h want 00", err_idx); end
    @(posedge clk); #1 arstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy %b want 0", busy); end
  endtask

  task automatic test_basic();
    int base;
    bit ok;
    logic [8:0] got;
    m_axis_tready = 1'b1; resp_en = 1'b1; nack_mask = 8'h00; plan_base = resp_frames;
    exp_q.delete(); push_e0(); push_e1();
    base = cap_q.size();
    pulse_start();
    @(negedge clk);
    checks++; if (busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL start_lat_t1: busy %b tvalid %b want 1 0", busy, m_axis_tvalid); end
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA0 || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL start_lat_t2: tvalid %b tdata %h tlast %b want 1 a0 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
    wait_end(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_wait: no done/error within 400 cycles"); end
    checks++; if (cap_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d beats want %0d", cap_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 9'bx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d: got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_status: done %b error %b busy %b want 1 0 0", done, error, busy); end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    logic [8:0] got;
    exp_q.delete(); push_e0(); push_e1();
    base = cap_q.size();
    pulse_start();
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_clear: done %b busy %b want 0 1", done, busy); end
    wait_end(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_wait: no done/error within 400 cycles"); end
    checks++; if (cap_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL b2b_len: got %0d beats want %0d", cap_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 9'bx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done); end
  endtask

  task automatic test_stall();
    int base;
    bit ok;
    bit prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    logic [8:0] got;
    nack_mask = 8'h00; plan_base = resp_frames;
    exp_q.delete(); push_e0(); push_e1();
    base = cap_q.size();
    m_axis_tready = 1'b0;
    pulse_start();
    ok = 1'b0; prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1 m_axis_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          errors++; $display("FAIL stall_hold: tvalid %b tdata %h tlast %b want 1 %h %b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
      if (done || error) begin ok = 1'b1; break; end
    end
    m_axis_tready = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL stall_wait: no done/error within 800 cycles"); end
    checks++; if (cap_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d beats want %0d", cap_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 9'bx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done); end
  endtask

`ifdef AXIS_I2C_CFG_RETRY_EN
  task automatic test_retry_recover();
    int base;
    bit ok;
    logic [8:0] got;
    nack_mask = 8'b0000_0110; plan_base = resp_frames;
    exp_q.delete(); push_e0(); push_e1(); push_e1(); push_e1();
    base = cap_q.size();
    pulse_start();
    wait_end(800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retry_ok_wait: no done/error within 800 cycles"); end
    checks++; if (cap_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL retry_ok_len: got %0d beats want %0d", cap_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 9'bx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL retry_ok_beat%0d: got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL retry_ok_status: done %b error %b want 1 0", done, error); end
  endtask

  task automatic test_retry_exhaust();
    int base;
    bit ok;
    logic [8:0] got;
    nack_mask = 8'b0001_1110; plan_base = resp_frames;
    exp_q.delete(); push_e0(); push_e1(); push_e1(); push_e1(); push_e1();
    base = cap_q.size();
    pulse_start();
    wait_end(900, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retry_ex_wait: no done/error within 900 cycles"); end
    checks++; if (cap_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL retry_ex_len: got %0d beats want %0d", cap_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 9'bx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL retry_ex_beat%0d: got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (error !== 1'b1 || done !== 1'b0 || err_idx !== 8'd1) begin errors++; $display("FAIL retry_ex_status: error %b done %b err_idx %0d want 1 0 1", error, done, err_idx); end
  endtask
`else
  task automatic test_nack_abort();
    int base;
    bit ok;
    bit prev_done;
    logic [8:0] got;
    nack_mask = 8'b0000_0001; plan_base = resp_frames;
    exp_q.delete(); push_e0();
    base = cap_q.size();
    pulse_start();
    ok = 1'b0; prev_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (error) begin ok = 1'b1; break; end
      prev_done = i2c_done;
    end
    checks++; if (!ok) begin errors++; $display("FAIL nack0_wait: no error within 200 cycles"); end
    checks++; if (prev_done !== 1'b1) begin errors++; $display("FAIL nack0_timing: i2c_done in prior cycle %b want 1", prev_done); end
    checks++; if (err_idx !== 8'd0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nack0_status: err_idx %0d done %b busy %b want 0 0 0", err_idx, done, busy); end
    checks++; if (cap_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL nack0_len: got %0d beats want %0d", cap_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 9'bx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL nack0_beat%0d: got %h want %h", i, got, exp_q[i]); end
    end
    nack_mask = 8'b0000_0010; plan_base = resp_frames;
    pulse_start();
    @(negedge clk);
    checks++; if (error !== 1'b0 || err_idx !== 8'd0) begin errors++; $display("FAIL nack_restart_clear: error %b err_idx %0d want 0 0", error, err_idx); end
    wait_end(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nack1_wait: no done/error within 400 cycles"); end
    checks++; if (error !== 1'b1 || err_idx !== 8'd1) begin errors++; $display("FAIL nack1_status: error %b err_idx %0d want 1 1", error, err_idx); end
  endtask
`endif

  task automatic test_timeout();
    bit ok;
    resp_en = 1'b0; m_axis_tready = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL tmo_frame: no tlast beat within 20 cycles"); end
    repeat (101) @(negedge clk);
    checks++; if (busy !== 1'b1 || error !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL tmo_w100: busy %b error %b tvalid %b want 1 0 0", busy, error, m_axis_tvalid); end
    @(negedge clk);
`ifdef AXIS_I2C_CFG_RETRY_EN
    checks++; if (busy !== 1'b1 || error !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL tmo_retry_load: busy %b error %b tvalid %b want 1 0 0", busy, error, m_axis_tvalid); end
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA0) begin errors++; $display("FAIL tmo_retry_resend: tvalid %b tdata %h want 1 a0", m_axis_tvalid, m_axis_tdata); end
`else
    checks++; if (error !== 1'b1 || err_idx !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL tmo_error: error %b err_idx %0d busy %b want 1 0 0", error, err_idx, busy); end
`endif
    arstn = 1'b0;
    @(posedge clk); #1 arstn = 1'b1;
    resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    int base;
    bit ok;
    logic [8:0] got;
    m_axis_tready = 1'b1; nack_mask = 8'h00; plan_base = resp_frames;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tdata == 8'h10) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_find_byte1: byte1 not seen within 10 cycles"); end
    arstn = 1'b0;
    #1;
    checks++; if ({m_axis_tvalid, m_axis_tlast, busy, done, error} !== 5'b0 || m_axis_tdata !== 8'h00 || err_idx !== 8'h00) begin
      errors++; $display("FAIL mid_reset_outputs: tvalid %b tlast %b busy %b done %b error %b tdata %h err_idx %h want all 0", m_axis_tvalid, m_axis_tlast, busy, done, error, m_axis_tdata, err_idx);
    end
    @(posedge clk); #1 arstn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_no_resume: tvalid %b busy %b want 0 0", m_axis_tvalid, busy); end
    exp_q.delete(); push_e0(); push_e1();
    base = cap_q.size();
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA0) begin errors++; $display("FAIL mid_restart_byte0: tvalid %b tdata %h want 1 a0", m_axis_tvalid, m_axis_tdata); end
    repeat (8) @(negedge clk);
    pulse_start();
    @(negedge clk);
    checks++; if (busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL busy_start_ignored: busy %b tvalid %b want 1 0", busy, m_axis_tvalid); end
    wait_end(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_wait: no done/error within 400 cycles"); end
    checks++; if (cap_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL mid_len: got %0d beats want %0d", cap_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 9'bx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL mid_beat%0d: got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL mid_status: done %b error %b want 1 0", done, error); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
`ifdef AXIS_I2C_CFG_RETRY_EN
    test_retry_recover();
    test_retry_exhaust();
`else
    test_nack_abort();
`endif
    test_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
